// File: rtl/lif_spike_monitor.sv
// lif_spike_monitor: collects per-window spike statistics from the LIF neuron
// core (spike count, minimum inter-spike interval, peak membrane state) and
// queues finished windows as records in a small FIFO. A valid/ready port
// drains the FIFO toward the chip I/O mux.
module lif_spike_monitor #(
  parameter int CNT_W      = 8,
  parameter int WIN_W      = 8,
  parameter int ISI_W      = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             clear_i,
  input  logic [WIN_W-1:0] win_len_i,
  input  logic             spike_i,
  input  logic [7:0]       state_i,
  output logic             rec_valid_o,
  input  logic             rec_ready_i,
  output logic [CNT_W-1:0] rec_count_o,
  output logic [ISI_W-1:0] rec_isi_min_o,
  output logic [7:0]       rec_peak_o,
  output logic             rec_ovf_o,
  output logic             drop_o
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int REC_W = CNT_W + ISI_W + 8 + 1;

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [ISI_W-1:0] ISI_MAX  = '1;
  localparam logic [AW:0]      FIFO_FULL = (AW+1)'(FIFO_DEPTH);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  // Window sequencing
  state_t           state_q;
  logic [WIN_W-1:0] win_cnt_q;
  logic [WIN_W-1:0] win_len_q;

  // Window accumulators and ISI tracking
  logic [CNT_W-1:0] count_q;
  logic [ISI_W-1:0] isi_min_q;
  logic [7:0]       peak_q;
  logic             ovf_q;
  logic [ISI_W-1:0] isi_cnt_q;
  logic             isi_valid_q;

  // Record FIFO
  logic [REC_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      fifo_cnt_q;

  // Combinational helpers
  logic [WIN_W-1:0] cnt_cur;
  logic [WIN_W-1:0] len_cur;
  logic             win_last;
  logic             step;
  logic [CNT_W-1:0] base_count;
  logic [ISI_W-1:0] base_isi;
  logic [7:0]       base_peak;
  logic             base_ovf;
  logic [CNT_W-1:0] acc_count;
  logic [ISI_W-1:0] acc_isi;
  logic [7:0]       acc_peak;
  logic             acc_ovf;
  logic [ISI_W-1:0] isi_interval;
  logic             fifo_empty;
  logic             fifo_full;
  logic             push;
  logic             pop;
  logic             wr_en;
  logic [REC_W-1:0] head;

  // Window position, end-of-window detection and this cycle's accumulated view
  always_comb begin
    step     = ena && !clear_i;
    // In IDLE the enabling cycle is the first window cycle, so the counter is
    // taken as zero and the length comes straight from the input.
    cnt_cur  = (state_q == IDLE) ? '0 : win_cnt_q;
    len_cur  = (cnt_cur == '0) ? win_len_i : win_len_q;
    win_last = (cnt_cur == len_cur);

    // Registered accumulators are only meaningful once a window is running;
    // the first window after reset/clear starts from fresh values.
    if (state_q == IDLE) begin
      base_count = '0;
      base_isi   = ISI_MAX;
      base_peak  = '0;
      base_ovf   = 1'b0;
    end else begin
      base_count = count_q;
      base_isi   = isi_min_q;
      base_peak  = peak_q;
      base_ovf   = ovf_q;
    end

    acc_count = base_count;
    acc_ovf   = base_ovf;
    if (spike_i) begin
      if (base_count == CNT_MAX) begin
        acc_ovf = 1'b1;
      end else begin
        acc_count = base_count + CNT_W'(1);
      end
    end

    isi_interval = (isi_cnt_q == ISI_MAX) ? ISI_MAX : isi_cnt_q + ISI_W'(1);
    acc_isi      = base_isi;
    if (spike_i && isi_valid_q && (isi_interval < base_isi)) begin
      acc_isi = isi_interval;
    end

    acc_peak = (state_i > base_peak) ? state_i : base_peak;
  end

  // FIFO handshake: a full FIFO still accepts a push when the head leaves the
  // same cycle; otherwise the finished record is dropped and flagged.
  always_comb begin
    fifo_empty = (fifo_cnt_q == '0);
    fifo_full  = (fifo_cnt_q == FIFO_FULL);
    push       = step && win_last;
    pop        = !fifo_empty && rec_ready_i && !clear_i;
    wr_en      = push && (!fifo_full || pop);
    drop_o     = push && fifo_full && !pop;
  end

  // FSM: track window start/length and the enabled-cycle position
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      win_cnt_q <= '0;
      win_len_q <= '0;
    end else if (clear_i) begin
      state_q   <= IDLE;
      win_cnt_q <= '0;
      win_len_q <= '0;
    end else if (ena) begin
      state_q <= RUN;
      if (cnt_cur == '0) begin
        win_len_q <= win_len_i;
      end
      win_cnt_q <= win_last ? '0 : cnt_cur + WIN_W'(1);
    end
  end

  // Accumulators restart after a window end; the ISI counter spans windows
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q     <= '0;
      isi_min_q   <= '0;
      peak_q      <= '0;
      ovf_q       <= 1'b0;
      isi_cnt_q   <= '0;
      isi_valid_q <= 1'b0;
    end else if (clear_i) begin
      count_q     <= '0;
      isi_min_q   <= '0;
      peak_q      <= '0;
      ovf_q       <= 1'b0;
      isi_cnt_q   <= '0;
      isi_valid_q <= 1'b0;
    end else if (step) begin
      if (win_last) begin
        count_q   <= '0;
        isi_min_q <= ISI_MAX;
        peak_q    <= '0;
        ovf_q     <= 1'b0;
      end else begin
        count_q   <= acc_count;
        isi_min_q <= acc_isi;
        peak_q    <= acc_peak;
        ovf_q     <= acc_ovf;
      end
      if (spike_i) begin
        isi_cnt_q   <= '0;
        isi_valid_q <= 1'b1;
      end else if (isi_cnt_q != ISI_MAX) begin
        isi_cnt_q <= isi_cnt_q + ISI_W'(1);
      end
    end
  end

  // Record storage, written only when a push is actually accepted
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_q] <= {acc_ovf, acc_peak, acc_isi, acc_count};
    end
  end

  // FIFO pointers and occupancy; clear flushes everything queued
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else if (clear_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      if (wr_en && !pop) begin
        fifo_cnt_q <= fifo_cnt_q + (AW+1)'(1);
      end else if (pop && !wr_en) begin
        fifo_cnt_q <= fifo_cnt_q - (AW+1)'(1);
      end
    end
  end

  // Head record drives the readout port; all fields read zero when empty
  always_comb begin
    head        = mem[rd_ptr_q];
    rec_valid_o = !fifo_empty;
    if (fifo_empty) begin
      rec_count_o   = '0;
      rec_isi_min_o = '0;
      rec_peak_o    = '0;
      rec_ovf_o     = 1'b0;
    end else begin
      {rec_ovf_o, rec_peak_o, rec_isi_min_o, rec_count_o} = head;
    end
  end

endmodule

// File: tb/tb_lif_spike_monitor.sv
// tb_lif_spike_monitor: directed, table-driven checks of lif_spike_monitor
// with hand-computed expected records, plus hand-written multi-cycle sequences.
module tb_lif_spike_monitor;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic       clear_i;
  logic [7:0] win_len_i;
  logic       spike_i;
  logic [7:0] state_i;
  logic       rec_valid_o;
  logic       rec_ready_i;
  logic [7:0] rec_count_o;
  logic [7:0] rec_isi_min_o;
  logic [7:0] rec_peak_o;
  logic       rec_ovf_o;
  logic       drop_o;

  int    n_vec;
  int    n_err;
  int    drops;
  string tag;

  typedef struct {
    logic       e;
    logic       c;
    logic [7:0] wl;
    logic       s;
    logic [7:0] st;
    logic       r;
    logic       x_drop;
    logic       x_valid;
    logic [7:0] x_count;
    logic [7:0] x_isi;
    logic [7:0] x_peak;
    logic       x_ovf;
  } vec_t;

  vec_t tbl[$];

  lif_spike_monitor #(
    .CNT_W(8), .WIN_W(8), .ISI_W(8), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .ena(ena),
    .clear_i(clear_i),
    .win_len_i(win_len_i),
    .spike_i(spike_i),
    .state_i(state_i),
    .rec_valid_o(rec_valid_o),
    .rec_ready_i(rec_ready_i),
    .rec_count_o(rec_count_o),
    .rec_isi_min_o(rec_isi_min_o),
    .rec_peak_o(rec_peak_o),
    .rec_ovf_o(rec_ovf_o),
    .drop_o(drop_o)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always ends
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mk(input logic e, input logic c, input logic [7:0] wl,
                              input logic s, input logic [7:0] st, input logic r,
                              input logic xd, input logic xv, input logic [7:0] xc,
                              input logic [7:0] xi, input logic [7:0] xp, input logic xo);
    vec_t v;
    v.e = e; v.c = c; v.wl = wl; v.s = s; v.st = st; v.r = r;
    v.x_drop = xd; v.x_valid = xv; v.x_count = xc;
    v.x_isi = xi; v.x_peak = xp; v.x_ovf = xo;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s %s: got %0d expected %0d", tag, name, act, exp);
    end
  endtask

  task automatic checkRecord(input logic xv, input logic [7:0] xc, input logic [7:0] xi,
                             input logic [7:0] xp, input logic xo);
    checkOutput("rec_valid", 8'(rec_valid_o), 8'(xv));
    checkOutput("rec_count", rec_count_o, xc);
    checkOutput("rec_isi_min", rec_isi_min_o, xi);
    checkOutput("rec_peak", rec_peak_o, xp);
    checkOutput("rec_ovf", 8'(rec_ovf_o), 8'(xo));
  endtask

  // Drive one cycle's inputs at the falling edge, check the combinational
  // drop flag before the rising edge, then step just past the rising edge.
  task automatic applyStimulus(input logic e, input logic c, input logic [7:0] wl,
                               input logic s, input logic [7:0] st, input logic r,
                               input logic xd);
    @(negedge clk);
    ena = e; clear_i = c; win_len_i = wl; spike_i = s; state_i = st; rec_ready_i = r;
    #1;
    if (drop_o === 1'b1) drops++;
    checkOutput("drop", 8'(drop_o), 8'(xd));
    @(posedge clk);
    #1;
  endtask

  task automatic doClear();
    tag = "clear";
    applyStimulus(1'b0, 1'b1, 8'd0, 1'b0, 8'd0, 1'b0, 1'b0);
    checkRecord(1'b0, 8'd0, 8'd0, 8'd0, 1'b0);
  endtask

  initial begin
    n_vec = 0; n_err = 0; drops = 0; tag = "reset";
    rst_n = 1'b0; ena = 1'b0; clear_i = 1'b0; win_len_i = 8'd0;
    spike_i = 1'b0; state_i = 8'd0; rec_ready_i = 1'b0;

    // Window of 4, no spikes, ramping state
    tbl.push_back(mk(1,0,3,0,10,0, 0,0,0,0,0,0));
    tbl.push_back(mk(1,0,3,0,20,0, 0,0,0,0,0,0));
    tbl.push_back(mk(1,0,3,0,30,0, 0,0,0,0,0,0));
    tbl.push_back(mk(1,0,3,0,40,0, 0,1,0,255,40,0));
    tbl.push_back(mk(0,0,3,0,99,0, 0,1,0,255,40,0));
    tbl.push_back(mk(0,1,3,0,0,0,  0,0,0,0,0,0));
    // Window of 8, spikes at 1,3,4, peak 77
    tbl.push_back(mk(1,0,7,1,5,0,  0,0,0,0,0,0));
    tbl.push_back(mk(1,0,7,0,77,0, 0,0,0,0,0,0));
    tbl.push_back(mk(1,0,7,1,5,0,  0,0,0,0,0,0));
    tbl.push_back(mk(1,0,7,1,5,0,  0,0,0,0,0,0));
    tbl.push_back(mk(1,0,7,0,5,0,  0,0,0,0,0,0));
    tbl.push_back(mk(1,0,7,0,5,0,  0,0,0,0,0,0));
    tbl.push_back(mk(1,0,7,0,5,0,  0,0,0,0,0,0));
    tbl.push_back(mk(1,0,7,0,5,0,  0,1,3,1,77,0));
    // Next window: spike at cycle 2 only (ISI 6 across boundary);
    // win_len_i changes mid-window and must be ignored
    tbl.push_back(mk(1,0,7,0,3,0,  0,1,3,1,77,0));
    tbl.push_back(mk(1,0,7,1,3,0,  0,1,3,1,77,0));
    tbl.push_back(mk(1,0,2,0,3,0,  0,1,3,1,77,0));
    tbl.push_back(mk(1,0,2,0,3,0,  0,1,3,1,77,0));
    tbl.push_back(mk(1,0,2,0,3,0,  0,1,3,1,77,0));
    tbl.push_back(mk(1,0,2,0,3,0,  0,1,3,1,77,0));
    tbl.push_back(mk(1,0,2,0,3,0,  0,1,3,1,77,0));
    tbl.push_back(mk(1,0,2,0,3,0,  0,1,3,1,77,0));
    tbl.push_back(mk(0,0,2,0,0,1,  0,1,1,6,3,0));
    tbl.push_back(mk(0,0,2,0,0,1,  0,0,0,0,0,0));
    tbl.push_back(mk(0,1,2,0,0,0,  0,0,0,0,0,0));

    #12;
    checkRecord(1'b0, 8'd0, 8'd0, 8'd0, 1'b0);
    checkOutput("drop", 8'(drop_o), 8'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      tag = $sformatf("tbl%0d", i);
      applyStimulus(tbl[i].e, tbl[i].c, tbl[i].wl, tbl[i].s, tbl[i].st, tbl[i].r, tbl[i].x_drop);
      checkRecord(tbl[i].x_valid, tbl[i].x_count, tbl[i].x_isi, tbl[i].x_peak, tbl[i].x_ovf);
    end

    // 1-cycle windows, continuous spikes, consumer always ready
    for (int i = 0; i < 5; i++) begin
      tag = $sformatf("win1_%0d", i);
      applyStimulus(1'b1, 1'b0, 8'd0, 1'b1, 8'(50 + i), 1'b1, 1'b0);
      checkRecord(1'b1, 8'd1, (i == 0) ? 8'd255 : 8'd1, 8'(50 + i), 1'b0);
    end
    tag = "win1_drain";
    applyStimulus(1'b0, 1'b0, 8'd0, 1'b0, 8'd0, 1'b1, 1'b0);
    checkRecord(1'b0, 8'd0, 8'd0, 8'd0, 1'b0);
    doClear();

    // 256-cycle window with 256 spikes saturates, then 255 spikes does not
    for (int i = 0; i < 256; i++) begin
      tag = $sformatf("sat_%0d", i);
      applyStimulus(1'b1, 1'b0, 8'd255, 1'b1, 8'(i), 1'b0, 1'b0);
      if (i == 254) checkRecord(1'b0, 8'd0, 8'd0, 8'd0, 1'b0);
    end
    tag = "sat_rec";
    checkRecord(1'b1, 8'd255, 8'd1, 8'd255, 1'b1);
    for (int i = 0; i < 256; i++) begin
      tag = $sformatf("nosat_%0d", i);
      applyStimulus(1'b1, 1'b0, 8'd255, (i < 255), 8'd7, 1'b0, 1'b0);
    end
    tag = "nosat_hold";
    checkRecord(1'b1, 8'd255, 8'd1, 8'd255, 1'b1);
    tag = "nosat_rec";
    applyStimulus(1'b0, 1'b0, 8'd255, 1'b0, 8'd0, 1'b1, 1'b0);
    checkRecord(1'b1, 8'd255, 8'd1, 8'd7, 1'b0);
    doClear();

    // FIFO overflow: 10 two-cycle windows, consumer stalled
    drops = 0;
    for (int w = 1; w <= 10; w++) begin
      for (int c = 0; c < 2; c++) begin
        tag = $sformatf("ovf_w%0d_c%0d", w, c);
        applyStimulus(1'b1, 1'b0, 8'd1, 1'b0, 8'(w), 1'b0, (c == 1) && (w >= 5));
      end
    end
    tag = "ovf_total";
    checkOutput("drop_count", 8'(drops), 8'd6);
    checkRecord(1'b1, 8'd0, 8'd255, 8'd1, 1'b0);
    // Push into a full FIFO while popping: no drop, order kept
    tag = "ovf_w11";
    applyStimulus(1'b1, 1'b0, 8'd1, 1'b0, 8'd11, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'd1, 1'b0, 8'd11, 1'b1, 1'b0);
    checkRecord(1'b1, 8'd0, 8'd255, 8'd2, 1'b0);
    begin
      logic [7:0] order [3];
      order[0] = 8'd3; order[1] = 8'd4; order[2] = 8'd11;
      for (int i = 0; i < 3; i++) begin
        tag = $sformatf("drain_%0d", i);
        applyStimulus(1'b0, 1'b0, 8'd1, 1'b0, 8'd0, 1'b1, 1'b0);
        checkRecord(1'b1, 8'd0, 8'd255, order[i], 1'b0);
      end
    end
    tag = "drain_end";
    applyStimulus(1'b0, 1'b0, 8'd1, 1'b0, 8'd0, 1'b1, 1'b0);
    checkRecord(1'b0, 8'd0, 8'd0, 8'd0, 1'b0);
    doClear();

    // Enable pause mid-window: spikes and state while ena=0 are ignored
    tag = "pause";
    applyStimulus(1'b1, 1'b0, 8'd3, 1'b1, 8'd9, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'd3, 1'b0, 8'd8, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tag = $sformatf("pause_off%0d", i);
      applyStimulus(1'b0, 1'b0, 8'd3, 1'b1, 8'd200, 1'b0, 1'b0);
      checkRecord(1'b0, 8'd0, 8'd0, 8'd0, 1'b0);
    end
    tag = "pause_c3";
    applyStimulus(1'b1, 1'b0, 8'd3, 1'b0, 8'd7, 1'b0, 1'b0);
    checkRecord(1'b0, 8'd0, 8'd0, 8'd0, 1'b0);
    tag = "pause_c4";
    applyStimulus(1'b1, 1'b0, 8'd3, 1'b1, 8'd6, 1'b0, 1'b0);
    checkRecord(1'b1, 8'd2, 8'd3, 8'd9, 1'b0);

    // Second record queued, then clear lands on the last cycle of a third window
    for (int i = 0; i < 7; i++) begin
      tag = $sformatf("preclr_%0d", i);
      applyStimulus(1'b1, 1'b0, 8'd3, 1'b0, 8'd1, 1'b0, 1'b0);
    end
    tag = "clr_last";
    applyStimulus(1'b1, 1'b1, 8'd3, 1'b0, 8'd1, 1'b0, 1'b0);
    checkRecord(1'b0, 8'd0, 8'd0, 8'd0, 1'b0);
    tag = "clr_after";
    applyStimulus(1'b0, 1'b0, 8'd3, 1'b0, 8'd0, 1'b0, 1'b0);
    checkRecord(1'b0, 8'd0, 8'd0, 8'd0, 1'b0);
    // ISI history was cleared, so a lone spike yields no interval
    tag = "clr_hist";
    applyStimulus(1'b1, 1'b0, 8'd0, 1'b1, 8'd33, 1'b0, 1'b0);
    checkRecord(1'b1, 8'd1, 8'd255, 8'd33, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/lif_spike_monitor.md
Name: lif_spike_monitor

Overview:
Downstream observer for the leaky integrate-and-fire neuron core. Consumes the neuron's per-cycle spike flag and 8-bit membrane state, and accumulates per-window statistics: spike count, minimum inter-spike interval, peak membrane state. Completed windows are pushed as records into a small FIFO, drained by a valid/ready readout port toward the chip I/O mux.

Parameters:
CNT_W, 8, spike-count field width (saturating)
WIN_W, 8, window-length control width
ISI_W, 8, inter-spike-interval counter width (saturating)
FIFO_DEPTH, 4, record FIFO entries (power of two, >=2)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
ena  input  1  design enable; low = pause (all counters and accumulators hold)
clear_i  input  1  synchronous clear: flush FIFO and accumulators, return to IDLE
win_len_i  input  WIN_W  window length minus one, in enabled cycles
spike_i  input  1  neuron spike flag, one cycle per spike
state_i  input  8  neuron membrane state, unsigned
rec_valid_o  output  1  FIFO head record valid
rec_ready_i  input  1  consumer accepts head when high with rec_valid_o
rec_count_o  output  CNT_W  spikes in window
rec_isi_min_o  output  ISI_W  minimum ISI completed in window; all-ones if none
rec_peak_o  output  8  max state_i in window
rec_ovf_o  output  1  spike count saturated in window
drop_o  output  1  one-cycle pulse: completed record lost because FIFO full

Behaviour:
- Reset (rst_n low, async): FSM=IDLE, FIFO empty, rec_valid_o=0, all record outputs 0, drop_o=0, accumulators 0, ISI history invalid.
- FSM IDLE: on first cycle with ena=1 latch win_len_i into win_len_q, clear window counter, go RUN; that cycle is the first window cycle and is accumulated.
- FSM RUN: each ena=1 cycle is one window cycle; ena=0 cycles are ignored entirely (no count, no ISI advance, no peak sampling, no window advance). FIFO pop still works while ena=0.
- Window = win_len_q+1 enabled cycles (win_len_i=0 -> 1-cycle windows). win_len_i re-latched at each window start; mid-window changes have no effect.
- Spike count: +1 per enabled cycle with spike_i=1; saturates at 2^CNT_W-1 and sets ovf for that window.
- ISI: counter of enabled cycles since last spike, saturating at 2^ISI_W-1; runs across window boundaries. On a spike with valid history, interval = counter+1 (adjacent-cycle spikes -> ISI 1), compared into window min; then counter reset, history valid. First spike after reset/clear only sets history.
- Peak: max of state_i over enabled window cycles, including first and last.
- Window end (last enabled cycle): record formed from accumulators including that cycle's inputs; pushed into FIFO; accumulators restart for next cycle (min ISI = all-ones, count/peak/ovf = 0).
- Latency: record visible on outputs, rec_valid_o=1, the cycle after the last window cycle if FIFO was empty.
- FIFO: pop when rec_valid_o & rec_ready_i. Push when full without simultaneous pop -> record discarded, drop_o=1 for that cycle, FIFO unchanged. Push when full with simultaneous pop -> both occur, no drop. Outputs hold stable while rec_valid_o=1 and not popped; record outputs drive 0 when empty.
- clear_i has priority over everything except reset: next cycle FSM=IDLE, FIFO empty, rec_valid_o=0, accumulators and ISI history cleared; an ending window on that cycle is discarded (no push, no drop).

Test Plan:
- Reset with ena=1, win_len_i=3, spike_i=0, state_i ramping 10,20,30,40 -> after 4 cycles record count=0, isi_min=255, peak=40, ovf=0; rec_valid_o rises on cycle 5.
- win_len_i=7, spikes at enabled cycles 1,3,4 -> record count=3, isi_min=1; next window spike at cycle 2 only -> isi_min=6 (interval spans boundary).
- win_len_i=0, spike_i held 1, rec_ready_i=1 -> record every cycle, count=1, isi_min=255 first then 1.
- win_len_i=255, spike_i held 1 for 256 cycles -> count=255, ovf=1.
- rec_ready_i=0, win_len_i=1, run 10 windows -> FIFO holds first 4 records, drop_o pulses 6 times; then assert rec_ready_i on a push cycle -> no drop, order preserved.
- Toggle ena low for 5 cycles mid-window with spike_i=1 -> counts and window position unchanged; clear_i mid-window with 2 queued records -> rec_valid_o=0 next cycle, no drop_o.
